axi_nport_arbiter: RTL and testbench

Parametrised AXI4 master arbiter that multiplexes NREQ simple request/response clients (instruction cache, LSU, CLINT-facing LSU path, DMA) onto one AXI4 master port. It holds one transaction in flight, latches the granted request, issues a single-beat read or write, and returns a registered one-cycle response to the owning client. The AXI ID carries the client index. The block sits between the pipeline memory clients and the SoC crossbar.

---
 rtl/axi_nport_arbiter_pkg.sv | 27 ++
 rtl/axi_arb_grant.sv | 65 ++++++
 rtl/axi_nport_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axi_nport_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_nport_arbiter_pkg.sv
// Shared definitions for the N-port AXI4 master arbiter: FSM encoding,
// fixed AXI field values and size codes.
package axi_nport_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_RSP   = 3'd5
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_arb_grant.sv
// Grant selection for the arbiter: one-hot grant and encoded index.
// AXI_ARB_ROUND_ROBIN_EN selects a rotating pointer; otherwise lowest index wins.
module axi_arb_grant
  import axi_nport_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_i,
  input  logic             take_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan starting at the pointer, wrapping around the client vector.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && req_i[(int'(ptr_q) + k) % NREQ]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_q) + k) % NREQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && any_o) begin
      ptr_d = (idx_o == IDX_W'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, take_i};

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
        any_o    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/axi_nport_arbiter.sv
// Multiplexes NREQ request/response clients onto one AXI4 master, one
// single-beat transaction in flight. Arbitration mode: AXI_ARB_ROUND_ROBIN_EN.
module axi_nport_arbiter
  import axi_nport_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*3-1:0]        req_size,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*DATA_W/8-1:0] req_wstrb,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [ID_W-1:0]          aw_id,
  output logic [ADDR_W-1:0]        aw_addr,
  output logic [7:0]               aw_len,
  output logic [2:0]               aw_size,
  output logic [1:0]               aw_burst,
  output logic                     aw_lock,
  output logic [3:0]               aw_cache,
  output logic [2:0]               aw_prot,
  output logic [3:0]               aw_qos,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [DATA_W-1:0]        w_data,
  output logic [DATA_W/8-1:0]      w_strb,
  output logic                     w_last,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ID_W-1:0]          b_id,
  input  logic [1:0]               b_resp,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [ID_W-1:0]          ar_id,
  output logic [ADDR_W-1:0]        ar_addr,
  output logic [7:0]               ar_len,
  output logic [2:0]               ar_size,
  output logic [1:0]               ar_burst,
  output logic                     ar_lock,
  output logic [3:0]               ar_cache,
  output logic [2:0]               ar_prot,
  output logic [3:0]               ar_qos,
  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic [ID_W-1:0]          r_id,
  input  logic [DATA_W-1:0]        r_data,
  input  logic [1:0]               r_resp,
  input  logic                     r_last
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                aw_done_q, w_done_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                err_q;

  logic [NREQ-1:0]     gnt;
  logic [IDX_W-1:0]    gidx;
  logic                any_req, take, aw_hs, w_hs;

  // Only one transaction is tracked, so response IDs and r_last carry no extra information.
  logic unused_axi;
  assign unused_axi = ^{b_id, r_id, r_last};

  axi_arb_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_valid),
    .take_i (take),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (any_req)
  );

  assign take  = (state_q == ST_IDLE) && any_req;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_req) state_d = req_write[gidx] ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (ar_ready) state_d = ST_RDATA;
      ST_RDATA: if (r_valid) state_d = ST_RSP;
      ST_WADDR: if ((aw_done_q || aw_ready) && (w_done_q || w_ready)) state_d = ST_WRESP;
      ST_WRESP: if (b_valid) state_d = ST_RSP;
      ST_RSP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
    end
  end

  // Request fields and response payload; rdata clears at grant so writes return 0.
  always_ff @(posedge clk) begin
    if (take) begin
      gidx_q  <= gidx;
      addr_q  <= req_addr[int'(gidx)*ADDR_W +: ADDR_W];
      size_q  <= req_size[int'(gidx)*3 +: 3];
      wdata_q <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
      wstrb_q <= req_wstrb[int'(gidx)*STRB_W +: STRB_W];
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
    if ((state_q == ST_RDATA) && r_valid) begin
      rdata_q <= r_data;
      err_q   <= resp_is_err(r_resp);
    end
    if ((state_q == ST_WRESP) && b_valid) err_q <= resp_is_err(b_resp);
  end

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == ST_RSP) ? (NREQ'(1) << gidx_q) : '0;
  assign rsp_rdata = (state_q == ST_RSP) ? rdata_q : '0;
  assign rsp_err   = (state_q == ST_RSP) && err_q;

  assign ar_valid = (state_q == ST_RADDR);
  assign ar_id    = ID_W'(gidx_q);
  assign ar_addr  = addr_q;
  assign ar_len   = LEN_SINGLE;
  assign ar_size  = size_q;
  assign ar_burst = BURST_INCR;
  assign ar_lock  = 1'b0;
  assign ar_cache = 4'b0011;
  assign ar_prot  = 3'b000;
  assign ar_qos   = 4'd0;
  assign r_ready  = (state_q == ST_RDATA);

  assign aw_valid = (state_q == ST_WADDR) && !aw_done_q;
  assign aw_id    = ID_W'(gidx_q);
  assign aw_addr  = addr_q;
  assign aw_len   = LEN_SINGLE;
  assign aw_size  = size_q;
  assign aw_burst = BURST_INCR;
  assign aw_lock  = 1'b0;
  assign aw_cache = 4'b0011;
  assign aw_prot  = 3'b000;
  assign aw_qos   = 4'd0;
  assign w_valid  = (state_q == ST_WADDR) && !w_done_q;
  assign w_data   = wdata_q;
  assign w_strb   = wstrb_q;
  assign w_last   = 1'b1;
  assign b_ready  = (state_q == ST_WRESP);

endmodule

// File: tb/tb_axi_nport_arbiter.sv
// Directed bench for axi_nport_arbiter: a 2-client 64-bit instance and a
// 4-client 32-bit instance, with the AXI slave side driven cycle by cycle.
module tb_axi_nport_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 2-client, 64-bit instance
  logic [1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [63:0]  req_addr;
  logic [5:0]   req_size;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [63:0]  rsp_rdata;
  logic         rsp_err;
  logic         aw_valid, aw_ready, aw_lock, w_valid, w_ready, w_last;
  logic [3:0]   aw_id, aw_cache, aw_qos;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size, aw_prot;
  logic [1:0]   aw_burst;
  logic [63:0]  w_data;
  logic [7:0]   w_strb;
  logic         b_valid, b_ready;
  logic [3:0]   b_id;
  logic [1:0]   b_resp;
  logic         ar_valid, ar_ready, ar_lock;
  logic [3:0]   ar_id, ar_cache, ar_qos;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size, ar_prot;
  logic [1:0]   ar_burst;
  logic         r_valid, r_ready, r_last;
  logic [3:0]   r_id;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;

  // 4-client, 32-bit instance
  logic [3:0]   req_valid4, req_write4, req_ready4, rsp_valid4;
  logic [127:0] req_addr4;
  logic [11:0]  req_size4;
  logic [127:0] req_wdata4;
  logic [15:0]  req_wstrb4;
  logic [31:0]  rsp_rdata4;
  logic         rsp_err4;
  logic         aw_valid4, aw_ready4, aw_lock4, w_valid4, w_ready4, w_last4;
  logic [3:0]   aw_id4, aw_cache4, aw_qos4;
  logic [31:0]  aw_addr4;
  logic [7:0]   aw_len4;
  logic [2:0]   aw_size4, aw_prot4;
  logic [1:0]   aw_burst4;
  logic [31:0]  w_data4;
  logic [3:0]   w_strb4;
  logic         b_valid4, b_ready4;
  logic [3:0]   b_id4;
  logic [1:0]   b_resp4;
  logic         ar_valid4, ar_ready4, ar_lock4;
  logic [3:0]   ar_id4, ar_cache4, ar_qos4;
  logic [31:0]  ar_addr4;
  logic [7:0]   ar_len4;
  logic [2:0]   ar_size4, ar_prot4;
  logic [1:0]   ar_burst4;
  logic         r_valid4, r_ready4, r_last4;
  logic [3:0]   r_id4;
  logic [31:0]  r_data4;
  logic [1:0]   r_resp4;

  axi_nport_arbiter #(.NREQ(2), .ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache),
    .aw_prot(aw_prot), .aw_qos(aw_qos),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache),
    .ar_prot(ar_prot), .ar_qos(ar_qos),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last)
  );

  axi_nport_arbiter #(.NREQ(4), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_write(req_write4), .req_addr(req_addr4), .req_size(req_size4),
    .req_wdata(req_wdata4), .req_wstrb(req_wstrb4), .req_ready(req_ready4),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .aw_valid(aw_valid4), .aw_ready(aw_ready4), .aw_id(aw_id4), .aw_addr(aw_addr4),
    .aw_len(aw_len4), .aw_size(aw_size4), .aw_burst(aw_burst4), .aw_lock(aw_lock4),
    .aw_cache(aw_cache4), .aw_prot(aw_prot4), .aw_qos(aw_qos4),
    .w_valid(w_valid4), .w_ready(w_ready4), .w_data(w_data4), .w_strb(w_strb4),
    .w_last(w_last4),
    .b_valid(b_valid4), .b_ready(b_ready4), .b_id(b_id4), .b_resp(b_resp4),
    .ar_valid(ar_valid4), .ar_ready(ar_ready4), .ar_id(ar_id4), .ar_addr(ar_addr4),
    .ar_len(ar_len4), .ar_size(ar_size4), .ar_burst(ar_burst4), .ar_lock(ar_lock4),
    .ar_cache(ar_cache4), .ar_prot(ar_prot4), .ar_qos(ar_qos4),
    .r_valid(r_valid4), .r_ready(r_ready4), .r_id(r_id4), .r_data(r_data4), .r_resp(r_resp4),
    .r_last(r_last4)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read through the 2-client instance; extra adds competing requesters.
  task automatic run_read(input string tg, input int c, input logic [1:0] extra,
                          input logic [31:0] addr, input logic [63:0] data,
                          input logic [1:0] resp);
    logic [1:0] oh;
    oh = 2'b01 << c;
    req_valid = oh | extra;
    req_write = 2'b00;
    req_addr[c*32 +: 32] = addr;
    req_size[c*3 +: 3] = 3'd3;
    ar_ready = 1'b1;
    #1;
    chk({tg, ".req_ready"}, 64'(req_ready), 64'(oh));
    tick();
    req_valid = 2'b00;
    #1;
    chk({tg, ".ar_valid"}, 64'(ar_valid), 64'd1);
    chk({tg, ".ar_id"}, 64'(ar_id), 64'(c));
    chk({tg, ".ar_addr"}, 64'(ar_addr), 64'(addr));
    chk({tg, ".ar_len_burst"}, 64'({ar_len, ar_burst}), 64'h01);
    tick();
    ar_ready = 1'b0;
    r_valid = 1'b1;
    r_data = data;
    r_resp = resp;
    r_last = 1'b1;
    #1;
    chk({tg, ".r_ready"}, 64'(r_ready), 64'd1);
    tick();
    r_valid = 1'b0;
    #1;
    chk({tg, ".rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tg, ".rsp_rdata"}, rsp_rdata, data);
    chk({tg, ".rsp_err"}, 64'(rsp_err), 64'(resp != 2'b00));
    tick();
    #1;
    chk({tg, ".rsp_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    req_valid = '0; req_write = '0; req_addr = '0; req_size = '0; req_wdata = '0; req_wstrb = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_id = '0; b_resp = '0;
    ar_ready = 0; r_valid = 0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b1;
    req_valid4 = '0; req_write4 = '0; req_addr4 = '0; req_size4 = '0; req_wdata4 = '0;
    req_wstrb4 = '0;
    aw_ready4 = 0; w_ready4 = 0; b_valid4 = 0; b_id4 = '0; b_resp4 = '0;
    ar_ready4 = 0; r_valid4 = 0; r_id4 = '0; r_data4 = '0; r_resp4 = '0; r_last4 = 1'b1;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst.valids", 64'({aw_valid, w_valid, ar_valid, r_ready, b_ready}), 64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk("rst.rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk("rst.rsp_rdata", rsp_rdata, 64'd0);
    tick();

    run_read("rd0", 0, 2'b00, 32'h8000_0000, 64'h1122_3344_5566_7788, 2'b00);

    // Write from client 1, AW accepted three cycles after W
    req_valid = 2'b10;
    req_write = 2'b10;
    req_addr[63:32] = 32'h1000_0040;
    req_size[5:3] = 3'd3;
    req_wdata[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
    req_wstrb[15:8] = 8'h0F;
    aw_ready = 1'b0;
    w_ready = 1'b1;
    #1;
    chk("wr.req_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 2'b00;
    req_write = 2'b00;
    #1;
    chk("wr.aw_w_valid", 64'({aw_valid, w_valid, w_last}), 64'h7);
    chk("wr.aw_id", 64'(aw_id), 64'd1);
    chk("wr.aw_len", 64'(aw_len), 64'd0);
    chk("wr.aw_addr", 64'(aw_addr), 64'h1000_0040);
    chk("wr.w_strb", 64'(w_strb), 64'h0F);
    chk("wr.w_data", w_data, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    #1;
    chk("wr.w_drop", 64'({aw_valid, w_valid}), 64'h2);
    tick();
    #1;
    chk("wr.aw_hold3", 64'(aw_valid), 64'd1);
    tick();
    aw_ready = 1'b1;
    #1;
    chk("wr.aw_hold4", 64'(aw_valid), 64'd1);
    tick();
    aw_ready = 1'b0;
    w_ready = 1'b0;
    b_valid = 1'b1;
    b_resp = 2'b00;
    b_id = 4'd1;
    #1;
    chk("wr.b_ready", 64'({aw_valid, b_ready}), 64'h1);
    tick();
    b_valid = 1'b0;
    #1;
    chk("wr.rsp_valid", 64'(rsp_valid), 64'h2);
    chk("wr.rsp_err", 64'(rsp_err), 64'd0);
    chk("wr.rsp_rdata", rsp_rdata, 64'd0);
    tick();

    // Both clients request continuously against a zero-wait slave
    req_valid = 2'b11;
    req_addr = {32'h2000_0100, 32'h2000_0000};
    req_size = {3'd3, 3'd3};
    ar_ready = 1'b1;
    r_valid = 1'b1;
    r_data = 64'h0F0F_0F0F_0F0F_0F0F;
    r_resp = 2'b00;
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk("arb.grant", 64'(req_ready), 64'(exp_g));
      tick();
      #1;
      chk("arb.ar_id", 64'(ar_id), 64'(exp_g == 2'b10));
      tick();
      tick();
      #1;
      chk("arb.rsp_owner", 64'(rsp_valid), 64'(exp_g));
      tick();
    end
    req_valid = 2'b00;
    ar_ready = 1'b0;
    r_valid = 1'b0;
    tick();

    run_read("slverr", 1, 2'b00, 32'h3000_0008, 64'h0000_0000_BAD0_BAD0, 2'b10);

    // Reset while waiting for read data
    req_valid = 2'b01;
    req_addr[31:0] = 32'h4000_0000;
    ar_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    ar_ready = 1'b0;
    #1;
    chk("rstmid.r_ready", 64'(r_ready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid.valids", 64'({aw_valid, w_valid, ar_valid, r_ready, b_ready}), 64'd0);
    chk("rstmid.rsp", 64'(rsp_valid), 64'd0);
    tick();
    #1;
    chk("rstmid.no_rsp", 64'(rsp_valid), 64'd0);
    run_read("postrst", 0, 2'b10, 32'h5000_0010, 64'h8877_6655_4433_2211, 2'b00);

    // 4-client, 32-bit instance: client 3 read
    req_valid4 = 4'b1000;
    req_write4 = 4'b0000;
    req_addr4[127:96] = 32'h0000_2000;
    req_size4[11:9] = 3'd2;
    ar_ready4 = 1'b1;
    #1;
    chk("n4.req_ready", 64'(req_ready4), 64'h8);
    tick();
    req_valid4 = 4'b0000;
    #1;
    chk("n4.ar_id", 64'(ar_id4), 64'd3);
    chk("n4.ar_addr", 64'(ar_addr4), 64'h2000);
    tick();
    ar_ready4 = 1'b0;
    r_valid4 = 1'b1;
    r_data4 = 32'hA5A5_5A5A;
    r_resp4 = 2'b00;
    tick();
    r_valid4 = 1'b0;
    #1;
    chk("n4.rsp_valid", 64'(rsp_valid4), 64'h8);
    chk("n4.rsp_rdata", 64'(rsp_rdata4), 64'hA5A5_5A5A);
    chk("n4.rsp_err", 64'(rsp_err4), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
